sweep_sequencer: RTL

Controller that sequences the up/down counter pair and owns the LED bus. On a start request it launches the up counter, the down counter, or both in turn (bounce). It repeats the pattern a programmed number of passes with a tick-counted gap between passes, and signals completion. It sits between the debounced button inputs and the two counter instances, replacing ad-hoc start/transition glue.

---
 rtl/sweep_sequencer_pkg.sv | 15 +
 rtl/sweep_sequencer_gap.sv | 27 ++
 rtl/sweep_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sweep_sequencer_pkg.sv
// Shared types and constants for the sweep sequencer and its gap timer.
package sweep_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DN     = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

endpackage

// File: rtl/sweep_sequencer_gap.sv
// Inter-pass gap timer: reloads on load, counts tick pulses down,
// flags the tick that completes the gap.
module gap_timer #(
  parameter int GAP_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int CW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)                     cnt <= '0;
    else if (load)                 cnt <= CW'(GAP_TICKS);
    else if (tick && cnt != '0)    cnt <= cnt - 1'b1;
  end

  // Fires combinationally on the last counted tick so the relaunch
  // pulse lands on the edge right after it.
  assign expired = tick && !load && (cnt == CW'(1));

endmodule

// File: rtl/sweep_sequencer.sv
// Sequences the up/down counter pair through repeated passes with a
// tick-counted gap, owns the LED bus and flags protocol violations.
import sweep_sequencer_pkg::*;

module sweep_sequencer #(
  parameter int WIDTH        = 8,
  parameter int REPEAT_WIDTH = 8,
  parameter int GAP_TICKS    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              mode,
  input  logic [REPEAT_WIDTH-1:0] repeats,
  input  logic                    done_up,
  input  logic                    done_dn,
  input  logic                    enabled_up,
  input  logic                    enabled_dn,
  input  logic [WIDTH-1:0]        value_up,
  input  logic [WIDTH-1:0]        value_dn,
  output logic                    start_up,
  output logic                    start_dn,
  output logic                    halt,
  output logic [WIDTH-1:0]        led,
  output logic                    busy,
  output logic                    finished,
  output logic [REPEAT_WIDTH-1:0] pass_count,
  output logic                    error
);

  state_t                  state, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [REPEAT_WIDTH-1:0] rep_q, rep_d;
  logic [REPEAT_WIDTH-1:0] pass_d, pass_inc;
  logic                    start_up_d, start_dn_d, halt_d, fin_d, err_d;
  logic                    launch, end_pass, gap_load, gap_expired;
  logic [1:0]              launch_mode;
  logic [WIDTH-1:0]        led_d;

  gap_timer #(.GAP_TICKS(GAP_TICKS)) u_gap (
    .clock   (clock),
    .reset   (reset),
    .load    (gap_load),
    .tick    (tick),
    .expired (gap_expired)
  );

  assign pass_inc = (pass_count == '1) ? pass_count : pass_count + 1'b1;

  always_comb begin
    state_d     = state;
    mode_d      = mode_q;
    rep_d       = rep_q;
    pass_d      = pass_count;
    start_up_d  = 1'b0;
    start_dn_d  = 1'b0;
    halt_d      = 1'b0;
    fin_d       = 1'b0;
    gap_load    = 1'b0;
    launch      = 1'b0;
    launch_mode = mode_q;
    end_pass    = 1'b0;

    // stop outranks any done or relaunch in every running state
    case (state)
      IDLE: begin
        if (start && !stop) begin
          mode_d      = mode;
          rep_d       = repeats;
          pass_d      = '0;
          launch      = 1'b1;
          launch_mode = mode;
        end
      end
      UP: begin
        if (stop) begin
          state_d = IDLE;
          halt_d  = 1'b1;
        end else if (done_up) begin
          if (mode_q[1]) begin
            state_d    = DN;
            start_dn_d = 1'b1;
          end else begin
            end_pass = 1'b1;
          end
        end
      end
      DN: begin
        if (stop) begin
          state_d = IDLE;
          halt_d  = 1'b1;
        end else if (done_dn) begin
          end_pass = 1'b1;
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
          halt_d  = 1'b1;
        end else if (gap_expired) begin
          launch = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (end_pass) begin
      pass_d = pass_inc;
      if (rep_q != '0 && pass_inc == rep_q) begin
        fin_d   = 1'b1;
        state_d = IDLE;
      end else if (GAP_TICKS == 0) begin
        launch = 1'b1;
      end else begin
        state_d  = GAP;
        gap_load = 1'b1;
      end
    end

    if (launch) begin
      if (launch_mode == MODE_DN) begin
        state_d    = DN;
        start_dn_d = 1'b1;
      end else begin
        state_d    = UP;
        start_up_d = 1'b1;
      end
    end
  end

  // Stray done pulses are only recorded; the FSM above already ignores them.
  assign err_d = error
               | (done_up && state != UP)
               | (done_dn && state != DN)
               | (enabled_up && enabled_dn);

  assign led_d = enabled_up ? value_up :
                 enabled_dn ? value_dn : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      mode_q     <= MODE_UP;
      rep_q      <= '0;
      pass_count <= '0;
      start_up   <= 1'b0;
      start_dn   <= 1'b0;
      halt       <= 1'b0;
      finished   <= 1'b0;
      error      <= 1'b0;
      led        <= '0;
    end else begin
      state      <= state_d;
      mode_q     <= mode_d;
      rep_q      <= rep_d;
      pass_count <= pass_d;
      start_up   <= start_up_d;
      start_dn   <= start_dn_d;
      halt       <= halt_d;
      finished   <= fin_d;
      error      <= err_d;
      led        <= led_d;
    end
  end

  assign busy = (state != IDLE);

endmodule
